// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller slice.
//   - FSM state encoding (3-bit) and the enum built on it
//   - Default NMI/maskable vector base and the spacing between maskable vectors
//   - Width of the source ID carried to the CPU
//   - Helper that turns a maskable source ID into its handler address
package int_pkg;

    localparam int ID_W = 4;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0008;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ_INT = 3'd1;
    localparam logic [2:0] ST_SVC_INT = 3'd2;
    localparam logic [2:0] ST_REQ_NMI = 3'd3;
    localparam logic [2:0] ST_SVC_NMI = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        REQ_INT = ST_REQ_INT,
        SVC_INT = ST_SVC_INT,
        REQ_NMI = ST_REQ_NMI,
        SVC_NMI = ST_SVC_NMI
    } state_t;

    // The NMI owns VEC_BASE itself, so maskable source k sits at slot k+1.
    // The arithmetic is 32-bit and wraps silently.
    function automatic logic [31:0] maskable_vector(input logic [31:0]     base,
                                                    input logic [31:0]     stride,
                                                    input logic [ID_W-1:0] id);
        logic [31:0] slot;
        slot = 32'(id) + 32'd1;
        return base + slot * stride;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the CPU / interrupt sources.
//   master : CPU and source side (drives levels, mask writes, ack/eoi)
//   slave  : the controller (drives requests, ID, vector, status)
// Signals:
//   irq_in, nmi_in       source levels (rising edge = request)
//   int_flag             CPU global enable for maskable requests
//   mask_we, mask_wdata  mask register write port (1 = masked)
//   int_ack, eoi         CPU handshake pulses
//   int_req, nmi_req     request lines to the CPU
//   int_id, int_vector   current source index and handler address
//   pending, in_service  status registers
interface interrupt_controller_if
    import int_pkg::*;
#(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] irq_in;
    logic             nmi_in;
    logic             int_flag;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             int_ack;
    logic             eoi;
    logic             int_req;
    logic             nmi_req;
    logic [ID_W-1:0]  int_id;
    logic [31:0]      int_vector;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] in_service;

    modport master (
        output irq_in, nmi_in, int_flag, mask_we, mask_wdata, int_ack, eoi,
        input  int_req, nmi_req, int_id, int_vector, pending, in_service
    );

    modport slave (
        input  irq_in, nmi_in, int_flag, mask_we, mask_wdata, int_ack, eoi,
        output int_req, nmi_req, int_id, int_vector, pending, in_service
    );

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : N request bits, bit 0 is the highest priority
//   valid : at least one request bit is set
//   index : position of the lowest set bit (0 when nothing is set)
module int_prio_enc
    import int_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] index
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front end sitting directly upstream of the CPU. It latches rising
// edges on N_SRC maskable sources and one NMI line, arbitrates them, and runs
// the request/acknowledge/end-of-interrupt handshake so that only one maskable
// handler is in service at a time. An NMI may preempt a maskable handler.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of interrupt_controller_if (sources, CPU handshake, status)
module interrupt_controller
    import int_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);

    state_t           state, state_next;
    logic [N_SRC-1:0] irq_prev, pending, mask, in_service;
    logic             nmi_prev, nmi_pend, preempt;
    logic             int_req_q, nmi_req_q;
    logic [ID_W-1:0]  int_id_q;
    logic [31:0]      vector_q;

    logic [N_SRC-1:0] irq_rise, eligible, id_onehot, pend_clr, svc_set;
    logic             nmi_rise, win_valid, latch_winner;
    logic             svc_clr_all, nmi_clr, preempt_set, preempt_clr;
    logic [ID_W-1:0]  win_index;

    assign irq_rise  = bus.irq_in & ~irq_prev;
    assign nmi_rise  = bus.nmi_in & ~nmi_prev;
    assign eligible  = pending & ~mask;
    assign id_onehot = N_SRC'(1) << int_id_q;

    int_prio_enc #(.N(N_SRC)) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .index (win_index)
    );

    // Next-state logic. The set/clear strobes are merged with the edge
    // detectors in the register block so a new edge always beats a clear.
    always_comb begin
        state_next   = state;
        latch_winner = 1'b0;
        pend_clr     = '0;
        svc_set      = '0;
        svc_clr_all  = 1'b0;
        nmi_clr      = 1'b0;
        preempt_set  = 1'b0;
        preempt_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (nmi_pend) begin
                    state_next = REQ_NMI;
                end else if (bus.int_flag && win_valid) begin
                    state_next   = REQ_INT;
                    latch_winner = 1'b1;
                end
            end
            REQ_INT: begin
                // An acknowledge that arrives together with a withdrawal
                // cause still commits the CPU to this source.
                if (bus.int_ack) begin
                    state_next = SVC_INT;
                    pend_clr   = id_onehot;
                    svc_set    = id_onehot;
                end else if (!bus.int_flag || (|(mask & id_onehot)) || nmi_pend) begin
                    state_next = IDLE;
                end
            end
            SVC_INT: begin
                if (nmi_pend) begin
                    state_next  = REQ_NMI;
                    preempt_set = 1'b1;
                end else if (bus.eoi) begin
                    state_next  = IDLE;
                    svc_clr_all = 1'b1;
                end
            end
            REQ_NMI: begin
                if (bus.int_ack) begin
                    state_next = SVC_NMI;
                    nmi_clr    = 1'b1;
                end
            end
            SVC_NMI: begin
                if (bus.eoi) begin
                    if (preempt) begin
                        state_next  = SVC_INT;
                        preempt_clr = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers. The previous-level registers load even
    // during reset so a level already high at release is not seen as an edge.
    always_ff @(posedge clk) begin
        irq_prev <= bus.irq_in;
        nmi_prev <= bus.nmi_in;
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '1;
            in_service <= '0;
            nmi_pend   <= 1'b0;
            preempt    <= 1'b0;
            int_req_q  <= 1'b0;
            nmi_req_q  <= 1'b0;
            int_id_q   <= '0;
            vector_q   <= '0;
        end else begin
            state      <= state_next;
            pending    <= (pending & ~pend_clr) | irq_rise;
            nmi_pend   <= (nmi_pend & ~nmi_clr) | nmi_rise;
            in_service <= svc_clr_all ? '0 : (in_service | svc_set);
            int_req_q  <= (state_next == REQ_INT);
            nmi_req_q  <= (state_next == REQ_NMI);
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
            if (preempt_set) begin
                preempt <= 1'b1;
            end else if (preempt_clr) begin
                preempt <= 1'b0;
            end
            // The vector follows whichever request is current; on return
            // from a preempting NMI it reverts to the interrupted source.
            if (latch_winner) begin
                int_id_q <= win_index;
                vector_q <= maskable_vector(VEC_BASE, VEC_STRIDE, win_index);
            end else if (state_next == REQ_NMI) begin
                vector_q <= VEC_BASE;
            end else if (preempt_clr) begin
                vector_q <= maskable_vector(VEC_BASE, VEC_STRIDE, int_id_q);
            end
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.nmi_req    = nmi_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.int_vector = vector_q;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;

endmodule
